// File: rtl/dac8563_cmd_sched.sv
// dac8563_cmd_sched: DAC8563 power-up init sequencer and round-robin A/B setpoint frame scheduler.
// Define DAC8563_SIMUL_UPDATE_EN to write A and B as a pair with a simultaneous update.
module dac8563_cmd_sched #(
  parameter int PWRUP_CYC = 25_000_000
) (
  input  logic        SYS_CLK,
  input  logic        RST_N,
  input  logic        req_a,
  input  logic [15:0] data_a,
  output logic        ack_a,
  input  logic        req_b,
  input  logic [15:0] data_b,
  output logic        ack_b,
  output logic        frame_valid,
  output logic [23:0] frame_data,
  input  logic        frame_ready,
  output logic        init_done
);
  localparam int CW = (PWRUP_CYC > 0) ? $clog2(PWRUP_CYC + 1) : 1;
  localparam logic [CW-1:0] PWR_MAX = CW'(PWRUP_CYC);
  localparam logic [2:0] S_PWR  = 3'd0;
  localparam logic [2:0] S_INIT = 3'd1;
  localparam logic [2:0] S_IDLE = 3'd2;
  localparam logic [2:0] S_SEND = 3'd3;
  localparam logic [2:0] S_ACK  = 3'd4;
  localparam logic [2:0] S_GAP  = 3'd5;
  logic [2:0]    state;
  logic [CW-1:0] cnt;
  logic [1:0]    idx;
  logic          last_b, gnt_a, gnt_b, pend_b, pick_a, hs;
  logic [23:0]   init_word;
  always_comb begin
    hs        = frame_valid & frame_ready;
    pick_a    = req_a & (~req_b | last_b);
    init_word = (idx == 2'd0) ? 24'h200003 : (idx == 2'd1) ? 24'h300003 : 24'h380001;
  end
  // valid drops for a cycle between frames so frame_data only moves while valid is low
  always_ff @(posedge SYS_CLK or negedge RST_N) begin
    if (!RST_N) begin
      state       <= S_PWR;
      cnt         <= '0;
      idx         <= '0;
      last_b      <= 1'b1;
      gnt_a       <= 1'b0;
      gnt_b       <= 1'b0;
      pend_b      <= 1'b0;
      ack_a       <= 1'b0;
      ack_b       <= 1'b0;
      frame_valid <= 1'b0;
      frame_data  <= '0;
      init_done   <= 1'b0;
    end else begin
      ack_a <= 1'b0;
      ack_b <= 1'b0;
      case (state)
        S_PWR: begin
          if (cnt == PWR_MAX) begin
            state       <= S_INIT;
            idx         <= '0;
            frame_valid <= 1'b1;
            frame_data  <= 24'h200003;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_INIT: begin
          if (hs) begin
            frame_valid <= 1'b0;
            idx         <= idx + 1'b1;
            if (idx == 2'd2) begin
              init_done <= 1'b1;
              state     <= S_IDLE;
            end
          end else if (!frame_valid) begin
            frame_valid <= 1'b1;
            frame_data  <= init_word;
          end
        end
        S_IDLE: begin
          if (req_a | req_b) begin
            frame_valid <= 1'b1;
            state       <= S_SEND;
`ifdef DAC8563_SIMUL_UPDATE_EN
            if (req_a & req_b) begin
              frame_data <= {8'h00, data_a};
              gnt_a      <= 1'b1;
              gnt_b      <= 1'b1;
              pend_b     <= 1'b1;
            end else begin
              frame_data <= pick_a ? {8'h18, data_a} : {8'h19, data_b};
              gnt_a      <= pick_a;
              gnt_b      <= ~pick_a;
              last_b     <= ~pick_a;
            end
`else
            frame_data <= pick_a ? {8'h18, data_a} : {8'h19, data_b};
            gnt_a      <= pick_a;
            gnt_b      <= ~pick_a;
            last_b     <= ~pick_a;
`endif
          end
        end
        S_SEND: begin
          if (hs) begin
            frame_valid <= 1'b0;
            if (pend_b) begin
              pend_b <= 1'b0;
              state  <= S_GAP;
            end else begin
              ack_a <= gnt_a;
              ack_b <= gnt_b;
              state <= S_ACK;
            end
          end
        end
        S_GAP: begin
          frame_valid <= 1'b1;
          frame_data  <= {8'h11, data_b};
          state       <= S_SEND;
        end
        S_ACK:   state <= S_IDLE;
        default: state <= S_PWR;
      endcase
    end
  end
endmodule

// File: doc/dac8563_cmd_sched.md
# dac8563_cmd_sched

Command scheduler for the DAC8563 dual 16-bit DAC. After power-up it sequences the device initialisation frames, then arbitrates between two setpoint requesters (channel A, channel B). It emits one 24-bit command frame at a time to the downstream SPI frame shifter over a valid/ready handshake. It sits between the MFC control loops and the SPI serializer and is the only writer of DAC command frames.

## Interface

Parameters:
- PWRUP_CYC, 25_000_000 — SYS_CLK cycles to wait after reset release before the first init frame (500 ms at 50 MHz); 0 = no wait.

Ports:
- SYS_CLK  in  1  system clock, all logic on rising edge.
- RST_N  in  1  asynchronous active-low reset.
- req_a  in  1  channel A write request; held high until ack_a.
- data_a  in  16  channel A code; stable while req_a is high.
- ack_a  out  1  one-cycle pulse; the channel A frame was accepted downstream.
- req_b  in  1  channel B write request; same rules as A.
- data_b  in  16  channel B code.
- ack_b  out  1  one-cycle pulse for channel B.
- frame_valid  out  1  frame_data holds a frame for the shifter.
- frame_data  out  24  frame, MSB first: {2'b00, C[2:0], A[2:0], D[15:0]}.
- frame_ready  in  1  shifter can take a frame; handshake = frame_valid & frame_ready on a rising edge.
- init_done  out  1  high once all init frames are accepted; stays high until reset.

## Operation

- Reset values: frame_valid=0, frame_data=0, ack_a=0, ack_b=0, init_done=0. State is S_PWR, delay counter is 0, RR pointer is "B last".
- S_PWR: counter increments to PWRUP_CYC, then goes to S_INIT with index 0. Counter width is $clog2(PWRUP_CYC+1), minimum 1.
- S_INIT: presents the init frames in order, one per handshake:
  - 0x200003: power up A and B.
  - 0x300003: LDAC pin unused.
  - 0x380001: internal reference enabled, gain 2.
  - After the third handshake: init_done goes high, state goes to S_IDLE.
- Requests that arrive during S_PWR or S_INIT stay pending and are not acked.
- S_IDLE arbitration:
  - One request: that channel is granted.
  - Both requests: the channel not granted last wins (round-robin); the pointer updates on each grant.
  - Neither request: stay in S_IDLE.
- Grant: data_x is captured into frame_data and the state goes to S_SEND.
  - Channel A frame: {8'h18, data_a}, command 011 (write and update n), address 000.
  - Channel B frame: {8'h19, data_b}, address 001.
- S_SEND: frame_valid=1 and frame_data held constant until the handshake, then go to S_ACK.
- S_ACK: the granted ack pulses for one cycle, frame_valid=0, then return to S_IDLE.
  - A requester sampling the ack drops req in the same cycle, so S_IDLE never re-grants a stale request.
- frame_valid never deasserts without a handshake. frame_data changes only while frame_valid=0.
- Reset mid-operation (any state): all outputs go to reset values immediately and initialisation restarts from S_PWR. The shifter shares RST_N, so a partial frame is discarded.

## Timing

- Request latency (A and B are symmetric):
  - req_a rises at cycle t while in S_IDLE.
  - frame_valid=1 at t+1.
  - With frame_ready=1, handshake at t+1, ack_a=1 at t+2, back in S_IDLE at t+3.
  - Minimum is 3 cycles per frame.
- Backpressure: each cycle frame_ready=0 adds one cycle. There is no timeout.
- Init: first frame_valid at cycle PWRUP_CYC+1 after reset release. init_done rises the cycle after the third handshake.
- frame_ready while frame_valid=0 is ignored.

## Configuration

- DAC8563_SIMUL_UPDATE_EN defined, and both requests are pending in S_IDLE:
  - Send {8'h00, data_a} (write input register A, no update).
  - Then send {8'h11, data_b} (write B, update all DAC registers).
  - ack_a and ack_b pulse together in S_ACK after the second handshake.
  - Both outputs change simultaneously. The RR pointer is unchanged.
  - A single pending request uses the normal 0x18/0x19 path.
- Macro undefined: only round-robin single-channel frames are sent; command 000/010 frames are never emitted.

## Test plan

- PWRUP_CYC=8, frame_ready=1 → frames 0x200003, 0x300003, 0x380001 with first valid at cycle 9; init_done=1 after the third; no other frames.
- After init: req_a with data_a=0x8000 → frame 0x188000 held until ready, one ack_a pulse, ack_b=0.
- Macro off: req_a=0x1234 and req_b=0x5678 together, held continuously → 0x181234, 0x195678, 0x181234, … alternating; each ack fires once per frame.
- Macro on: same simultaneous request → 0x001234 then 0x115678; ack_a and ack_b high in the same single cycle.
- frame_ready=0 for 10 cycles during S_SEND → frame_data stable, frame_valid high, no ack; handshake on cycle 11, ack next cycle.
- RST_N pulsed low mid-S_SEND → frame_valid/acks/init_done=0 asynchronously; after release the full init sequence repeats before any pending request is served.
